mips_exec_decode_unit: RTL and testbench

- Single-cycle decode-and-execute slice of the pipelined MIPS core.
- Takes one 32-bit instruction plus its two register operands and the PC+4 value.
- Produces:
  - the 8-bit main control word;
  - the 4-bit ALU control code;
  - the ALU result and zero flag;
  - the branch target and destination register.
- All outputs are registered, giving one cycle of latency. Sits between register-file read and the EX/MEM pipeline register.

---
 rtl/mips_exec_pkg.sv | 52 +++++
 rtl/mips_exec_decode_unit_alu32_core.sv | 29 ++
 rtl/mips_exec_decode_unit.sv | 152 +++++++++++++++
 tb/tb_mips_exec_decode_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_exec_pkg.sv
// Shared constants for the MIPS decode/execute slice: opcodes, funct codes,
// ALU control codes, main-control words and ctrl bit positions.
package mips_exec_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    // Bit positions inside the 8-bit main control word
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // Main control words
    localparam logic [7:0] CTRL_RTYPE = 8'b1001_0010;
    localparam logic [7:0] CTRL_LW    = 8'b0111_0000;
    localparam logic [7:0] CTRL_SW    = 8'b0100_1000;
    localparam logic [7:0] CTRL_BEQ   = 8'b0000_0101;
    localparam logic [7:0] CTRL_ADDI  = 8'b0101_0000;
    localparam logic [7:0] CTRL_NONE  = 8'h00;

    // 16-bit immediate to 32-bit two's-complement value
    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_exec_decode_unit_alu32_core.sv
// alu32_core: purely combinational 32-bit ALU. Undefined control codes
// (including ALU_NONE) produce zero so that nop yields a zero result.
module alu32_core
    import mips_exec_pkg::*;
(
    input  logic [3:0]  alu_ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; add/sub wrap modulo 2^32, slt compares signed
    always_comb begin
        result = 32'd0;
        case (alu_ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_NOR: result = ~(a | b);
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_exec_decode_unit.sv
// mips_exec_decode_unit: single-cycle decode + execute slice with registered
// outputs (one cycle latency). Optional macro MIPS_ADDI_EN adds addi decode.
module mips_exec_decode_unit
    import mips_exec_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] pc_plus4,
    output logic          out_valid,
    output logic [7:0]    ctrl,
    output logic [3:0]    alu_ctl,
    output logic [DW-1:0] alu_result,
    output logic          zero,
    output logic [DW-1:0] branch_target,
    output logic          branch_taken,
    output logic [4:0]    write_reg,
    output logic [DW-1:0] store_data
);

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;

    assign w_opcode = instr[31:26];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_imm    = instr[15:0];
    assign w_funct  = instr[5:0];
    assign w_simm   = sign_ext16(w_imm);

    logic [7:0]  w_ctrl;
    logic [1:0]  w_aluop;
    logic [3:0]  w_alu_ctl;
    logic [31:0] w_op_b;
    logic [31:0] w_result;
    logic        w_zero;
    logic [31:0] w_target;
    logic [4:0]  w_write_reg;

    // Main control decode from opcode
    always_comb begin
        w_ctrl = CTRL_NONE;
        case (w_opcode)
            OP_RTYPE: w_ctrl = CTRL_RTYPE;
            OP_LW:    w_ctrl = CTRL_LW;
            OP_SW:    w_ctrl = CTRL_SW;
            OP_BEQ:   w_ctrl = CTRL_BEQ;
`ifdef MIPS_ADDI_EN
            OP_ADDI:  w_ctrl = CTRL_ADDI;
`endif
            default:  w_ctrl = CTRL_NONE;
        endcase
    end

    assign w_aluop = w_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];

    // ALU control decode from ALUOp and, for R-type, funct
    always_comb begin
        w_alu_ctl = ALU_NONE;
        case (w_aluop)
            2'b00: w_alu_ctl = ALU_ADD;
            2'b01: w_alu_ctl = ALU_SUB;
            2'b11: w_alu_ctl = ALU_ADD;
            default: begin
                case (w_funct)
                    FN_ADD:  w_alu_ctl = ALU_ADD;
                    FN_SUB:  w_alu_ctl = ALU_SUB;
                    FN_AND:  w_alu_ctl = ALU_AND;
                    FN_OR:   w_alu_ctl = ALU_OR;
                    FN_SLT:  w_alu_ctl = ALU_SLT;
                    FN_NOR:  w_alu_ctl = ALU_NOR;
                    default: w_alu_ctl = ALU_NONE;
                endcase
            end
        endcase
    end

    assign w_op_b      = w_ctrl[CTRL_ALUSRC] ? w_simm : rt_data;
    assign w_target    = pc_plus4 + {w_simm[29:0], 2'b00};
    assign w_write_reg = w_ctrl[CTRL_REGDST] ? w_rd : w_rt;

    alu32_core u_alu (
        .alu_ctl (w_alu_ctl),
        .a       (rs_data),
        .b       (w_op_b),
        .result  (w_result),
        .zero    (w_zero)
    );

    logic        r_out_valid;
    logic [7:0]  r_ctrl;
    logic [3:0]  r_alu_ctl;
    logic [31:0] r_alu_result;
    logic        r_zero;
    logic [31:0] r_branch_target;
    logic        r_branch_taken;
    logic [4:0]  r_write_reg;
    logic [31:0] r_store_data;

    // Valid tracks in_valid every cycle; reset clears any in-flight instruction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
        end
    end

    // Data outputs capture only on a valid input and hold otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl          <= 8'h00;
            r_alu_ctl       <= 4'h0;
            r_alu_result    <= 32'd0;
            r_zero          <= 1'b0;
            r_branch_target <= 32'd0;
            r_branch_taken  <= 1'b0;
            r_write_reg     <= 5'd0;
            r_store_data    <= 32'd0;
        end else if (in_valid) begin
            r_ctrl          <= w_ctrl;
            r_alu_ctl       <= w_alu_ctl;
            r_alu_result    <= w_result;
            r_zero          <= w_zero;
            r_branch_target <= w_target;
            r_branch_taken  <= w_ctrl[CTRL_BRANCH] & w_zero;
            r_write_reg     <= w_write_reg;
            r_store_data    <= rt_data;
        end
    end

    assign out_valid     = r_out_valid;
    assign ctrl          = r_ctrl;
    assign alu_ctl       = r_alu_ctl;
    assign alu_result    = r_alu_result;
    assign zero          = r_zero;
    assign branch_target = r_branch_target;
    assign branch_taken  = r_branch_taken;
    assign write_reg     = r_write_reg;
    assign store_data    = r_store_data;

endmodule

// File: tb/tb_mips_exec_decode_unit.sv
// Directed testbench for mips_exec_decode_unit. Expected values are
// hand-computed; addi expectations follow MIPS_ADDI_EN.
module tb_mips_exec_decode_unit;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc_plus4;
    logic        out_valid;
    logic [7:0]  ctrl;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [4:0]  write_reg;
    logic [31:0] store_data;

    int n_assert = 0;
    int n_fail   = 0;

    mips_exec_decode_unit #(.DW(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .instr         (instr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .pc_plus4      (pc_plus4),
        .out_valid     (out_valid),
        .ctrl          (ctrl),
        .alu_ctl       (alu_ctl),
        .alu_result    (alu_result),
        .zero          (zero),
        .branch_target (branch_target),
        .branch_taken  (branch_taken),
        .write_reg     (write_reg),
        .store_data    (store_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one input set at the falling edge, then sample 1ns after the capture edge
    task automatic apply(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc);
        @(negedge clock);
        in_valid = v;
        instr    = ins;
        rs_data  = a;
        rt_data  = b;
        pc_plus4 = pc;
        @(posedge clock);
        #1;
        $display("txn v=%0b instr=%h rs=%h rt=%h pc=%h -> ov=%0b ctrl=%h alu=%h res=%h z=%0b tgt=%h bt=%0b wr=%0d sd=%h",
                 v, ins, a, b, pc, out_valid, ctrl, alu_ctl, alu_result, zero,
                 branch_target, branch_taken, write_reg, store_data);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        instr    = 32'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        pc_plus4 = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {24'd0, ctrl}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // slt 4 < 7
        apply(1'b1, 32'h0109502A, 32'd4, 32'd7, 32'h100);
        chk("slt_valid", {31'd0, out_valid}, 32'd1);
        chk("slt_ctrl", {24'd0, ctrl}, 32'h92);
        chk("slt_aluctl", {28'd0, alu_ctl}, 32'h7);
        chk("slt_result", alu_result, 32'd1);
        chk("slt_zero", {31'd0, zero}, 32'd0);
        chk("slt_wreg", {27'd0, write_reg}, 32'd10);
        chk("slt_target", branch_target, 32'h141A8);

        // slt 7 < 4 is false
        apply(1'b1, 32'h0109502A, 32'd7, 32'd4, 32'h100);
        chk("slt_swap_result", alu_result, 32'd0);
        chk("slt_swap_zero", {31'd0, zero}, 32'd1);

        // slt is signed: -1 < 1
        apply(1'b1, 32'h0109502A, 32'hFFFFFFFF, 32'd1, 32'h100);
        chk("slt_signed", alu_result, 32'd1);

        // sub 4 - 7
        apply(1'b1, 32'h01095022, 32'd4, 32'd7, 32'h100);
        chk("sub_aluctl", {28'd0, alu_ctl}, 32'h6);
        chk("sub_result", alu_result, 32'hFFFFFFFD);
        chk("sub_zero", {31'd0, zero}, 32'd0);

        // add wrap-around to zero
        apply(1'b1, 32'h01095020, 32'hFFFFFFFF, 32'd1, 32'h100);
        chk("add_wrap_result", alu_result, 32'd0);
        chk("add_wrap_zero", {31'd0, zero}, 32'd1);

        // and / or / nor
        apply(1'b1, 32'h01095024, 32'h0000F0F0, 32'h0000FF00, 32'h100);
        chk("and_result", alu_result, 32'h0000F000);
        apply(1'b1, 32'h01095025, 32'h0000F0F0, 32'h0000FF00, 32'h100);
        chk("or_result", alu_result, 32'h0000FFF0);
        apply(1'b1, 32'h01095027, 32'h0000F0F0, 32'h0000FF00, 32'h100);
        chk("nor_aluctl", {28'd0, alu_ctl}, 32'hC);
        chk("nor_result", alu_result, 32'hFFFF000F);

        // lw: base 0 + offset 4, writes rt
        apply(1'b1, 32'h8C090004, 32'd0, 32'h55, 32'h100);
        chk("lw_ctrl", {24'd0, ctrl}, 32'h70);
        chk("lw_aluctl", {28'd0, alu_ctl}, 32'h2);
        chk("lw_result", alu_result, 32'd4);
        chk("lw_wreg", {27'd0, write_reg}, 32'd9);

        // sw: store data passes through, address = rs + 4
        apply(1'b1, 32'hAC080004, 32'h100, 32'd7, 32'h100);
        chk("sw_ctrl", {24'd0, ctrl}, 32'h48);
        chk("sw_store", store_data, 32'd7);
        chk("sw_result", alu_result, 32'h104);

        // beq taken
        apply(1'b1, 32'h11400005, 32'd0, 32'd0, 32'h28);
        chk("beq_ctrl", {24'd0, ctrl}, 32'h05);
        chk("beq_zero", {31'd0, zero}, 32'd1);
        chk("beq_taken", {31'd0, branch_taken}, 32'd1);
        chk("beq_target", branch_target, 32'h3C);

        // beq not taken
        apply(1'b1, 32'h11400005, 32'd1, 32'd0, 32'h28);
        chk("beq_nt_taken", {31'd0, branch_taken}, 32'd0);

        // beq backward offset (-1 word)
        apply(1'b1, 32'h1000FFFF, 32'd0, 32'd0, 32'h28);
        chk("beq_back_target", branch_target, 32'h24);

        // nop
        apply(1'b1, 32'h00000000, 32'h1234, 32'h5678, 32'h100);
        chk("nop_ctrl", {24'd0, ctrl}, 32'h92);
        chk("nop_aluctl", {28'd0, alu_ctl}, 32'hF);
        chk("nop_result", alu_result, 32'd0);
        chk("nop_zero", {31'd0, zero}, 32'd1);
        chk("nop_wreg", {27'd0, write_reg}, 32'd0);

        // addi: immediate add when enabled, otherwise treated as unknown (add rs+rt)
        apply(1'b1, 32'h2108FFFF, 32'd5, 32'd3, 32'h100);
`ifdef MIPS_ADDI_EN
        chk("addi_ctrl", {24'd0, ctrl}, 32'h50);
        chk("addi_result", alu_result, 32'd4);
`else
        chk("addi_ctrl", {24'd0, ctrl}, 32'h00);
        chk("addi_result", alu_result, 32'd8);
`endif

        // hold: in_valid low keeps data, drops out_valid
        apply(1'b1, 32'h01095022, 32'd4, 32'd7, 32'h100);
        apply(1'b0, 32'h8C090004, 32'd0, 32'd0, 32'h0);
        chk("hold_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_result", alu_result, 32'hFFFFFFFD);
        chk("hold_ctrl", {24'd0, ctrl}, 32'h92);

        // reset mid-stream with a valid instruction in flight
        @(negedge clock);
        in_valid = 1'b1;
        instr    = 32'h0109502A;
        rs_data  = 32'd4;
        rt_data  = 32'd7;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_ctrl", {24'd0, ctrl}, 32'd0);
        chk("midrst_result", alu_result, 32'd0);
        chk("midrst_wreg", {27'd0, write_reg}, 32'd0);
        chk("midrst_target", branch_target, 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
        apply(1'b1, 32'h0109502A, 32'd4, 32'd7, 32'h100);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_result", alu_result, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
